// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the oversampling UART blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int unsigned OVERSAMPLE = 16;

  // Majority-vote sample positions within a 16-tick bit; the vote resolves on VOTE_T2
  localparam int unsigned VOTE_T0 = 7;
  localparam int unsigned VOTE_T1 = 8;
  localparam int unsigned VOTE_T2 = 9;

  // Clocks per oversample tick, truncated
  function automatic int unsigned calc_div(input int unsigned clk_mhz,
                                           input int unsigned baud);
    return (clk_mhz * 1000000) / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: enable-gated divider emitting a one-clk tick every DIV clocks.
// Held at zero while disabled so the first tick lands DIV clocks after enable.
module uart_baud_tick #(
  parameter int unsigned DIV = 54
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

  if (DIV < 2) begin : g_bad_div
    $error("uart_baud_tick: DIV must be at least 2");
  end

  logic [CW-1:0] cnt_q;

  // Count while enabled, restart from zero whenever disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (!en) begin
      cnt_q <= '0;
      tick  <= 1'b0;
    end else if (cnt_q == CW'(DIV - 1)) begin
      cnt_q <= '0;
      tick  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + CW'(1);
      tick  <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampling UART receiver with 3-sample majority vote,
// start-glitch rejection, frame/parity error flags and overrun reporting.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRE    = 100,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_pin,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_data_valid,
  input  logic                 rx_data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int unsigned DIV = calc_div(CLK_FRE, BAUD_RATE);
  localparam int unsigned TW  = $clog2(OVERSAMPLE);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_os: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_os: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_rx_os: PARITY_ODD must be 0 or 1");
  end

  rx_state_e            state_q;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic                 tick, tick_en;
  logic [TW-1:0]        tick_cnt_q, tick_idx;
  logic                 s7_q, s8_q;
  logic                 vote, vote_now;
  logic [DATA_BITS-1:0] shift_q;
  logic [3:0]           bit_cnt_q;
  logic                 stop_cnt_q;
  logic                 ferr_q, ferr_next;
  logic                 can_load;
`ifdef UART_RX_PARITY_EN
  localparam logic ODD = 1'(PARITY_ODD);
  logic perr_q;
`endif

  // Two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_pin;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign tick_en = (state_q != IDLE);

  uart_baud_tick #(
    .DIV(DIV)
  ) u_baud_tick (
    .clk (clk),
    .rst (rst),
    .en  (tick_en),
    .tick(tick)
  );

  // tick_idx is the position (mod 16) reached by the current tick
  assign tick_idx  = tick_cnt_q + TW'(1);
  assign vote_now  = tick && (tick_idx == TW'(VOTE_T2));
  assign vote      = (s7_q & s8_q) | (s7_q & rx_sync_q) | (s8_q & rx_sync_q);
  assign ferr_next = ferr_q | ~vote;
  // A finished frame may enter the output register unless an unaccepted word is held
  assign can_load  = ~rx_data_valid | rx_data_ready;

  // Sub-bit tick position and the two early vote samples; counter parked at 0 in IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      s7_q       <= 1'b0;
      s8_q       <= 1'b0;
    end else if (!tick_en) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= tick_idx;
      if (tick_idx == TW'(VOTE_T0)) s7_q <= rx_sync_q;
      if (tick_idx == TW'(VOTE_T1)) s8_q <= rx_sync_q;
    end
  end

  // Frame FSM with registered output word, flags and overrun pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      stop_cnt_q    <= 1'b0;
      ferr_q        <= 1'b0;
      rx_data       <= '0;
      rx_data_valid <= 1'b0;
      frame_err     <= 1'b0;
      overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q        <= 1'b0;
      parity_err    <= 1'b0;
`endif
    end else begin
      overrun <= 1'b0;
      if (rx_data_valid && rx_data_ready) rx_data_valid <= 1'b0;

      unique case (state_q)
        IDLE: begin
          // Needs a 1->0 transition, so a held break cannot re-trigger
          if (rx_prev_q && !rx_sync_q) state_q <= START;
        end
        START: begin
          if (vote_now) begin
            state_q    <= vote ? IDLE : DATA;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            ferr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q     <= 1'b0;
`endif
          end
        end
        DATA: begin
          if (vote_now) begin
            shift_q <= {vote, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (vote_now) begin
            perr_q  <= vote ^ (^shift_q) ^ ODD;
            state_q <= STOP;
          end
        end
`endif
        STOP: begin
          if (vote_now) begin
            if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
              // Commit at the last stop vote so the next start edge is not missed
              state_q <= IDLE;
              if (can_load) begin
                rx_data       <= shift_q;
                frame_err     <= ferr_next;
                rx_data_valid <= 1'b1;
`ifdef UART_RX_PARITY_EN
                parity_err    <= perr_q;
`endif
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              stop_cnt_q <= 1'b1;
              ferr_q     <= ferr_next;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed bench for uart_rx_os. Instance a uses default parameters;
// instance b runs 9 data bits, 2 stop bits, odd parity at 625 kbaud (DIV = 10).
module tb_uart_rx_os;
  import uart_pkg::*;

`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // Bit periods in hundredths of a 100 MHz clock
  localparam int BIT_A      = 86806;
  localparam int BIT_B      = 16000;
  localparam int BIT_B_FAST = 15534;
  localparam int BIT_B_SLOW = 16480;

  typedef struct {
    logic [8:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, rx_a, rx_b, ready_a, ready_b;
  logic [7:0] data_a;
  logic [8:0] data_b;
  logic       val_a, val_b, ferr_a, ferr_b, perr_a, perr_b, ovr_o_a, ovr_o_b;

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t e;
  int   n_pass = 0;
  int   n_checks = 0;
  int   vcyc_a = 0;
  int   vcyc_b = 0;
  int   ovr_a = 0;
  int   ovr_b = 0;
  int   v0, o0;

  always #5 clk = ~clk;

  uart_rx_os dut_a (
    .clk          (clk),
    .rst          (rst_a),
    .rx_pin       (rx_a),
    .rx_data      (data_a),
    .rx_data_valid(val_a),
    .rx_data_ready(ready_a),
    .frame_err    (ferr_a),
    .parity_err   (perr_a),
    .overrun      (ovr_o_a)
  );

  uart_rx_os #(
    .CLK_FRE   (100),
    .BAUD_RATE (625000),
    .DATA_BITS (9),
    .STOP_BITS (2),
    .PARITY_ODD(1)
  ) dut_b (
    .clk          (clk),
    .rst          (rst_b),
    .rx_pin       (rx_b),
    .rx_data      (data_b),
    .rx_data_valid(val_b),
    .rx_data_ready(ready_b),
    .frame_err    (ferr_b),
    .parity_err   (perr_b),
    .overrun      (ovr_o_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Presented word must match the oldest expected frame; handshake retires it
  always @(negedge clk) begin
    if (!rst_a) begin
      if (ovr_o_a) ovr_a++;
      if (val_a) begin
        vcyc_a++;
        check("a_word_expected", 32'(exp_a.size() > 0), 32'd1);
        if (exp_a.size() > 0) begin
          check("a_data", 32'(data_a), 32'(exp_a[0].data[7:0]));
          check("a_frame_err", 32'(ferr_a), 32'(exp_a[0].ferr));
          check("a_parity_err", 32'(perr_a), 32'(exp_a[0].perr));
          if (ready_a) void'(exp_a.pop_front());
        end
      end
    end
    if (!rst_b) begin
      if (ovr_o_b) ovr_b++;
      if (val_b) begin
        vcyc_b++;
        check("b_word_expected", 32'(exp_b.size() > 0), 32'd1);
        if (exp_b.size() > 0) begin
          check("b_data", 32'(data_b), 32'(exp_b[0].data));
          check("b_frame_err", 32'(ferr_b), 32'(exp_b[0].ferr));
          check("b_parity_err", 32'(perr_b), 32'(exp_b[0].perr));
          if (ready_b) void'(exp_b.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_rx(input bit sel, input logic v);
    if (sel) rx_b = v;
    else rx_a = v;
  endtask

  // Drive one frame; when deliver is set, queue what the receiver must report for it
  task automatic send(input bit sel, input logic [8:0] data, input int bit_x100,
                      input bit stop_low, input bit par_flip, input bit deliver);
    logic [15:0] bits;
    logic [8:0]  d;
    logic        odd, pbit;
    int          nb, t, target;
    exp_t        x;
    d    = sel ? data : {1'b0, data[7:0]};
    odd  = sel;
    bits = '1;
    bits[0] = 1'b0;
    nb = 1;
    for (int i = 0; i < (sel ? 9 : 8); i++) begin
      bits[nb] = d[i];
      nb++;
    end
    pbit = (^d) ^ odd ^ par_flip;
    if (PAR_EN) begin
      bits[nb] = pbit;
      nb++;
    end
    for (int s = 0; s < (sel ? 2 : 1); s++) begin
      bits[nb] = ~stop_low;
      nb++;
    end
    if (deliver) begin
      x.data = d;
      x.ferr = stop_low;
      x.perr = PAR_EN && (pbit != ((^d) ^ odd));
      if (sel) exp_b.push_back(x);
      else exp_a.push_back(x);
    end
    t = 0;
    for (int k = 0; k < nb; k++) begin
      set_rx(sel, bits[k]);
      target = ((k + 1) * bit_x100) / 100;
      while (t < target) begin
        @(posedge clk);
        #1;
        t++;
      end
    end
    set_rx(sel, 1'b1);
  endtask

  task automatic drain(input bit sel, input string name);
    int n;
    n = 0;
    while ((sel ? exp_b.size() : exp_a.size()) != 0 && n < 5000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(name, 32'(sel ? exp_b.size() : exp_a.size()), 32'd0);
  endtask

  initial begin
    rx_a = 1'b1;
    rx_b = 1'b1;
    ready_a = 1'b1;
    ready_b = 1'b1;
    rst_a = 1'b1;
    rst_b = 1'b1;
    idle(5);
    check("a_rst_data", 32'(data_a), 32'd0);
    check("a_rst_valid", 32'(val_a), 32'd0);
    check("a_rst_ferr", 32'(ferr_a), 32'd0);
    check("a_rst_perr", 32'(perr_a), 32'd0);
    check("a_rst_overrun", 32'(ovr_o_a), 32'd0);
    check("b_rst_data", 32'(data_b), 32'd0);
    check("b_rst_valid", 32'(val_b), 32'd0);
    check("b_rst_ferr", 32'(ferr_b), 32'd0);
    check("b_rst_perr", 32'(perr_b), 32'd0);
    check("b_rst_overrun", 32'(ovr_o_b), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    idle(5);

    // 0xA5 at 115200 with ready high: one valid cycle, no flags
    v0 = vcyc_a;
    send(1'b0, 9'h0A5, BIT_A, 1'b0, 1'b0, 1'b1);
    drain(1'b0, "a_A5_drained");
    check("a_A5_valid_cycles", 32'(vcyc_a - v0), 32'd1);
    check("a_A5_data_lit", 32'(data_a), 32'h0A5);

    // Back-to-back with consumer stalled: second frame dropped, first held
    ready_a = 1'b0;
    send(1'b0, 9'h03C, BIT_A, 1'b0, 1'b0, 1'b1);
    idle(200);
    send(1'b0, 9'h0C3, BIT_A, 1'b0, 1'b0, 1'b0);
    idle(100);
    check("a_overrun_pulses", 32'(ovr_a), 32'd1);
    check("a_held_valid", 32'(val_a), 32'd1);
    check("a_held_data_lit", 32'(data_a), 32'h03C);
    ready_a = 1'b1;
    drain(1'b0, "a_3C_drained");

    // 3% fast and 3% slow line rates on the widest frame
    send(1'b1, 9'h1FF, BIT_B_FAST, 1'b0, 1'b0, 1'b1);
    idle(320);
    send(1'b1, 9'h155, BIT_B_FAST, 1'b0, 1'b0, 1'b1);
    idle(320);
    send(1'b1, 9'h1FF, BIT_B_SLOW, 1'b0, 1'b0, 1'b1);
    idle(320);
    send(1'b1, 9'h0AA, BIT_B_SLOW, 1'b0, 1'b0, 1'b1);
    drain(1'b1, "b_drift_drained");

    // 300 ns low glitch: rejected at the start vote
    v0 = vcyc_b;
    rx_b = 1'b0;
    idle(30);
    rx_b = 1'b1;
    idle(200);
    check("b_glitch_state_idle", 32'(dut_b.state_q), 32'(IDLE));
    check("b_glitch_no_valid", 32'(vcyc_b - v0), 32'd0);

    // Stop bits low: word still delivered, flagged
    send(1'b1, 9'h055, BIT_B, 1'b1, 1'b0, 1'b1);
    idle(320);
    drain(1'b1, "b_ferr_drained");
    check("b_ferr_lit", 32'(ferr_b), 32'd1);
    check("b_ferr_data_lit", 32'(data_b), 32'h055);

    // Break for 20 bit times: one all-zero frame with frame_err, then normal traffic
    e.data = 9'h000;
    e.ferr = 1'b1;
    e.perr = PAR_EN && (1'b0 != (1'b0 ^ 1'b1));
    exp_b.push_back(e);
    rx_b = 1'b0;
    idle(3200);
    rx_b = 1'b1;
    idle(320);
    drain(1'b1, "b_break_drained");
    send(1'b1, 9'h012, BIT_B, 1'b0, 1'b0, 1'b1);
    idle(320);
    drain(1'b1, "b_after_break_drained");
    check("b_after_break_data_lit", 32'(data_b), 32'h012);
    check("b_after_break_ferr_lit", 32'(ferr_b), 32'd0);

`ifdef UART_RX_PARITY_EN
    send(1'b1, 9'h007, BIT_B, 1'b0, 1'b0, 1'b1);
    idle(320);
    drain(1'b1, "b_par_ok_drained");
    check("b_par_ok_lit", 32'(perr_b), 32'd0);
    send(1'b1, 9'h007, BIT_B, 1'b0, 1'b1, 1'b1);
    idle(320);
    drain(1'b1, "b_par_bad_drained");
    check("b_par_bad_lit", 32'(perr_b), 32'd1);
`endif

    // Reset mid-frame while a word is held: valid cleared, no output, no overrun
    ready_b = 1'b0;
    send(1'b1, 9'h0A5, BIT_B, 1'b0, 1'b0, 1'b1);
    v0 = 0;
    while (!val_b && v0 < 500) begin
      @(posedge clk);
      #1;
      v0++;
    end
    check("b_pre_rst_valid", 32'(val_b), 32'd1);
    o0 = ovr_b;
    // Line stays high from the reset point onward, so no false start follows
    fork
      send(1'b1, 9'h1F8, BIT_B, 1'b0, 1'b0, 1'b0);
      begin
        idle(1040);
        rst_b = 1'b1;
        idle(3);
        rst_b = 1'b0;
      end
    join
    check("b_rst_valid_cleared", 32'(val_b), 32'd0);
    check("b_rst_no_overrun", 32'(ovr_b - o0), 32'd0);
    exp_b.delete();
    ready_b = 1'b1;
    idle(320);
    send(1'b1, 9'h007, BIT_B, 1'b0, 1'b0, 1'b1);
    idle(320);
    drain(1'b1, "b_post_rst_drained");
    check("b_post_rst_data_lit", 32'(data_b), 32'h007);

    check("a_total_overruns", 32'(ovr_a), 32'd1);
    check("b_total_overruns", 32'(ovr_b), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
